ram_read_streamer: RTL and testbench

Read-side sequencer for a 1-write/1-read block RAM in the Multi MAC datapath. On `start` it walks a contiguous, wrap-around address range and issues one read per cycle, absorbing the RAM's 1-cycle read latency. It returns the rows as a valid/ready stream with full back-pressure support and no data loss. It sits directly downstream of the row buffer RAM and feeds the MAC array's operand input.

---
 rtl/mm_pkg.sv | 13 +
 rtl/skid_fifo2.sv | 61 ++++++
 rtl/ram_read_streamer.sv | 140 ++++++++++++++
 tb/tb_ram_read_streamer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and default sizing for the Multi MAC datapath blocks.
package mm_pkg;

    localparam int DATA_WIDTH_DEF = 4096;
    localparam int DEPTH_DEF      = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rs_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO; the head register drives the stream directly so
// downstream sees no combinational path from the write data.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [1:0]   count_r;
    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;

    // Storage update; pop is only ever asserted while count_r is non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 2'd0;
            head_r  <= {W{1'b0}};
            tail_r  <= {W{1'b0}};
        end else begin
            case (count_r)
                2'd0: begin
                    if (push) begin
                        head_r  <= push_data;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_r <= push_data;
                    end else if (push) begin
                        tail_r  <= push_data;
                        count_r <= 2'd2;
                    end else if (pop) begin
                        count_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_r <= tail_r;
                        if (push) begin
                            tail_r <= push_data;
                        end else begin
                            count_r <= 2'd1;
                        end
                    end
                end
                default: count_r <= 2'd0;
            endcase
        end
    end

    assign count = count_r;
    assign head  = head_r;

endmodule

// File: rtl/ram_read_streamer.sv
// Walks a wrap-around RAM row range, one read per cycle, and returns the rows
// as a valid/ready stream with a 2-entry buffer absorbing the read latency.
module ram_read_streamer
    import mm_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int DEPTH      = DEPTH_DEF,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [CW-1:0]         num_rows,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    rs_state_t       state_r, state_s;
    logic [CW-1:0]   issued_r, sent_r, num_rows_r;
    logic [AW-1:0]   addr_r;
    logic            inflight_r, busy_r, done_r;
    logic            issue_s, accept_s, done_set_s, pop_s, credit_ok_s, last_beat_s;
    logic [1:0]      fifo_count_s;
    logic [2:0]      occupancy_s;

    // Wrap by compare so non-power-of-2 depths stay inside the RAM.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return a + AW'(1);
        end
    endfunction

    assign m_valid     = (fifo_count_s != 2'd0);
    assign pop_s       = m_valid & m_ready;
    assign last_beat_s = (sent_r == num_rows_r - CW'(1));
    assign m_last      = m_valid & last_beat_s;
    // Buffered rows plus the read landing next edge must leave room for a new read.
    assign occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r};
    assign credit_ok_s = occupancy_s < (3'd2 + {2'b00, pop_s});

    // Next-state, issue and completion decode.
    always_comb begin
        state_s    = state_r;
        issue_s    = 1'b0;
        accept_s   = 1'b0;
        done_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    done_set_s = (num_rows == {CW{1'b0}});
                    state_s    = (num_rows == {CW{1'b0}}) ? FLUSH : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                issue_s = (issued_r < num_rows_r) && credit_ok_s;
                if (issue_s && (issued_r == num_rows_r - CW'(1))) begin
                    state_s = FLUSH;
                end else begin
                    state_s = RUN;
                end
            end
            FLUSH: begin
                if (num_rows_r == {CW{1'b0}}) begin
                    state_s = IDLE;
                end else if (pop_s && last_beat_s) begin
                    state_s    = IDLE;
                    done_set_s = 1'b1;
                end else begin
                    state_s = FLUSH;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, counters, read address and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            issued_r   <= {CW{1'b0}};
            sent_r     <= {CW{1'b0}};
            num_rows_r <= {CW{1'b0}};
            addr_r     <= {AW{1'b0}};
            inflight_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= issue_s;
            done_r     <= done_set_s;
            busy_r     <= (state_s != IDLE) || done_set_s;
            if (accept_s) begin
                issued_r   <= {CW{1'b0}};
                sent_r     <= {CW{1'b0}};
                num_rows_r <= num_rows;
                if (num_rows != {CW{1'b0}}) begin
                    addr_r <= base_addr;
                end
            end else begin
                if (issue_s) begin
                    issued_r <= issued_r + CW'(1);
                    addr_r   <= next_addr(addr_r);
                end
                if (pop_s) begin
                    sent_r <= sent_r + CW'(1);
                end
            end
        end
    end

    skid_fifo2 #(
        .W(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_r),
        .push_data(ram_dout),
        .pop      (pop_s),
        .count    (fifo_count_s),
        .head     (m_data)
    );

    assign busy          = busy_r;
    assign done          = done_r;
    assign ram_read_addr = addr_r;

endmodule

// File: tb/tb_ram_read_streamer.sv
// Directed bench for ram_read_streamer with a queue-based reference model.
module tb_ram_read_streamer;

    localparam int DW = 32;
    localparam int DP = 64;

    logic          clk = 1'b0;
    logic          rst, start, m_ready;
    logic [5:0]    base_addr;
    logic [6:0]    num_rows;
    logic          busy, done, m_valid, m_last;
    logic [5:0]    ram_read_addr;
    logic [DW-1:0] ram_dout, m_data;
    logic [DW-1:0] mem [0:DP-1];

    int vecs = 0;
    int errs = 0;

    ram_read_streamer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .busy(busy), .done(done),
        .ram_read_addr(ram_read_addr), .ram_dout(ram_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= mem[ram_read_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of the row indices still owed to the stream.
    logic [5:0]    exp_q[$];
    bit            model_en = 1'b0, model_active = 1'b0, zero_release = 1'b0;
    bit            exp_done = 1'b0, exp_busy = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (model_en) begin
            bit act_now, n_done;
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("data", m_data, mem[exp_q[0]]);
                    chk("last", m_last, exp_q.size() == 1);
                end
            end else begin
                chk("last_idle", m_last, 0);
            end
            if (rst) begin
                exp_q.delete();
                model_active = 1'b0;
                zero_release = 1'b0;
                exp_done     = 1'b0;
                exp_busy     = 1'b0;
                prev_stall   = 1'b0;
            end else begin
                act_now = model_active;
                n_done  = 1'b0;
                if (zero_release) begin
                    model_active = 1'b0;
                    zero_release = 1'b0;
                end
                if (m_valid && m_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        n_done       = 1'b1;
                        model_active = 1'b0;
                    end
                end
                if (start && !act_now) begin
                    model_active = 1'b1;
                    if (num_rows == 7'd0) begin
                        zero_release = 1'b1;
                        n_done       = 1'b1;
                    end else begin
                        for (int k = 0; k < int'(num_rows); k++)
                            exp_q.push_back(6'((int'(base_addr) + k) % DP));
                    end
                end
                exp_done   = n_done;
                exp_busy   = model_active || n_done;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    task automatic do_start(input logic [5:0] b, input logic [6:0] n);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        num_rows  = n;
    endtask

    task automatic run_until_done(input logic [63:0] pat, input int inj, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk); #1;
            start = (i == inj);
            if (i == inj) begin
                base_addr = 6'd40;
                num_rows  = 7'd3;
            end
            m_ready = pat[i % 64];
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_all_rows"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [5:0] addr_before;
        for (int i = 0; i < DP; i++) mem[i] = 32'hC0DE_0000 + i;
        rst = 1'b1; start = 1'b0; m_ready = 1'b1;
        base_addr = 6'd0; num_rows = 7'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_addr", ram_read_addr, 0);
        chk("rst_data", m_data, 0);
        model_en = 1'b1;

        // Rows 5..8: beats in cycles 3..6, last on row 8, done in cycle 7.
        do_start(6'd5, 7'd4);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (c == 1) chk("t1_addr_c1", ram_read_addr, 6'd5);
            chk("t1_valid", m_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk("t1_data", m_data, 32'hC0DE_0002 + c);
            chk("t1_last", m_last, c == 6);
            chk("t1_done", done, c == 7);
            chk("t1_busy", busy, c <= 7);
        end

        // Wrap-around 62,63,0,1.
        do_start(6'd62, 7'd4);
        run_until_done(64'hFFFF_FFFF_FFFF_FFFF, -1, "wrap");

        // Back-pressure with a 10-cycle stall while rows are buffered.
        do_start(6'd17, 7'd8);
        run_until_done(64'hFFFF_FFFF_FFF0_0369, -1, "stall");

        // Zero rows: no beat, address unchanged, done one cycle after start.
        do_start(6'd33, 7'd0);
        @(negedge clk);
        addr_before = ram_read_addr;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("zero_addr", ram_read_addr, addr_before);
            chk("zero_done", done, c == 1);
            chk("zero_valid", m_valid, 0);
        end

        // A second start mid-transfer is ignored.
        do_start(6'd20, 7'd6);
        run_until_done(64'hFFFF_FFFF_FFFF_FFFF, 2, "restart");

        // Reset with one row buffered and one in flight.
        m_ready = 1'b0;
        do_start(6'd10, 7'd6);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_data", m_data, 32'hC0DE_000A);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", m_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        @(posedge clk); #1 m_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_done2", done, 0);
        chk("post_rst_valid2", m_valid, 0);
        do_start(6'd30, 7'd3);
        run_until_done(64'hFFFF_FFFF_FFFF_FFFF, -1, "after_rst");

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
